// File: rtl/tt_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_gate_pkg
// Description : Shared op-code enum, debounce counter width and the per-lane
//               gate evaluation function for the gate array.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_gate_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } gate_op_e;

    localparam int c_DEB_W = 4;

    function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_gate_deb.sv
`default_nettype none
// ============================================================================
// Module      : tt_gate_deb
// Description : One gate channel: op register, gate evaluation, stability
//               counter, debounced output Q and change flag F.
//               GATE_STICKY_EN makes F sticky until cleared by i_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_gate_deb
    import tt_gate_pkg::*;
#(
    parameter int DEB = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ena,
    input  logic       i_op_wr,
    input  logic [1:0] i_op_data,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_clr,
    output logic       o_q,
    output logic       o_f
);

    localparam logic [c_DEB_W-1:0] c_LAST = c_DEB_W'(DEB - 1);

    gate_op_e           r_op;
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_q;
    logic               r_f;
    logic               w_r;
    logic               w_fire;

    assign w_r    = gate_eval(r_op, i_a, i_b);
    assign w_fire = (w_r != r_q) && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= OP_AND;
            r_cnt <= '0;
            r_q   <= 1'b0;
            r_f   <= 1'b0;
        end else if (i_ena) begin
            if (i_op_wr) begin
                r_op <= gate_op_e'(i_op_data);
            end
            // Count only while R disagrees with Q; agreeing or committing restarts.
            if ((w_r == r_q) || w_fire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fire) begin
                r_q <= w_r;
            end
`ifdef GATE_STICKY_EN
            r_f <= w_fire | (r_f & ~i_clr);
`else
            r_f <= w_fire;
`endif
        end
    end

`ifndef GATE_STICKY_EN
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
`endif

    assign o_q = r_q;
    assign o_f = r_f;

endmodule
`default_nettype wire

// File: rtl/tt_um_gate_array.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_gate_array
// Description : CH-channel programmable gate array with debounced outputs and
//               change flags. Macro GATE_STICKY_EN selects sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_gate_array
    import tt_gate_pkg::*;
#(
    parameter int CH  = 4,
    parameter int DEB = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [CH-1:0] r_a;
    logic [CH-1:0] r_b;
    logic [CH-1:0] w_q;
    logic [CH-1:0] w_f;
    logic [3:0]    w_q_pad;
    logic [3:0]    w_f_pad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (ena) begin
            r_a <= ui_in[CH-1:0];
            r_b <= ui_in[4 +: CH];
        end
    end

    // Channel indices >= CH have no matching lane, so such writes vanish.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic w_wr;
        assign w_wr = uio_in[4] && (uio_in[3:2] == 2'(i));

        tt_gate_deb #(
            .DEB (DEB)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .i_ena     (ena),
            .i_op_wr   (w_wr),
            .i_op_data (uio_in[1:0]),
            .i_a       (r_a[i]),
            .i_b       (r_b[i]),
            .i_clr     (uio_in[5]),
            .o_q       (w_q[i]),
            .o_f       (w_f[i])
        );
    end

    always_comb begin
        w_q_pad         = '0;
        w_f_pad         = '0;
        w_q_pad[CH-1:0] = w_q;
        w_f_pad[CH-1:0] = w_f;
    end

    assign uo_out  = {w_f_pad, w_q_pad};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic w_unused;
    assign w_unused = ^{uio_in[7:5], ui_in};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_gate_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_gate_array
// Description : Self-checking bench for tt_um_gate_array (CH=4 and CH=2, DEB=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_gate_array;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo4, uio_out4, uio_oe4;
    logic [7:0] uo2, uio_out2, uio_oe2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    tt_um_gate_array #(.CH(4), .DEB(DEB)) u_dut (
        .clk (clk), .rst (rst), .ena (ena), .ui_in (ui_in), .uio_in (uio_in),
        .uo_out (uo4), .uio_out (uio_out4), .uio_oe (uio_oe4)
    );

    tt_um_gate_array #(.CH(2), .DEB(DEB)) u_dut2 (
        .clk (clk), .rst (rst), .ena (ena), .ui_in (ui_in), .uio_in (uio_in),
        .uo_out (uo2), .uio_out (uio_out2), .uio_oe (uio_oe2)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Gate truth tables indexed by {a,b}: AND, OR, XOR, NAND.
    logic [3:0] tt [4];
    logic [1:0] m_op [4];
    int         m_run [4];
    logic [3:0] m_a, m_b, m_q, m_f;
    bit         m_valid = 1'b0;

    initial tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};

    task automatic model_step();
        logic [3:0] fired;
        logic       r;
        fired = 4'b0;
        if (rst) begin
            m_a = '0; m_b = '0; m_q = '0; m_f = '0;
            for (int i = 0; i < 4; i++) begin
                m_op[i]  = 2'b00;
                m_run[i] = 0;
            end
            m_valid = 1'b1;
        end else if (ena && m_valid) begin
            for (int i = 0; i < 4; i++) begin
                r = tt[m_op[i]][{m_a[i], m_b[i]}];
                if (r == m_q[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        fired[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            m_q = m_q ^ fired;
`ifdef GATE_STICKY_EN
            m_f = fired | (m_f & ~{4{uio_in[5]}});
`else
            m_f = fired;
`endif
            if (uio_in[4]) m_op[uio_in[3:2]] = uio_in[1:0];
            m_a = ui_in[3:0];
            m_b = ui_in[7:4];
        end
    endtask

    // Every cycle: advance the model on the edge, then compare both DUTs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            if (m_valid) begin
                check("model_uo_ch4", uo4, {m_f, m_q});
                check("model_uo_ch2", uo2, {m_f, m_q} & 8'h33);
                check("uio_out_ch4", uio_out4, 8'h00);
                check("uio_oe_ch4", uio_oe4, 8'h00);
                check("uio_out_ch2", uio_out2, 8'h00);
                check("uio_oe_ch2", uio_oe2, 8'h00);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_flags();
        uio_in = 8'h20;
        tick();
        uio_in = 8'h00;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        tick(2);
        check("reset_uo", uo4, 8'h00);

        // First enabled cycles after reset; Q[0] rises DEB edges after sampling.
        rst = 1'b0; ena = 1'b1; ui_in = 8'h11;
        tick(3);
        check("latency_before", uo4, 8'h00);
        tick();
        check("latency_rise", uo4, 8'h11);
        tick();
`ifdef GATE_STICKY_EN
        check("flag_after_rise", uo4, 8'h11);
`else
        check("flag_pulse_end", uo4, 8'h01);
`endif
        ui_in = 8'h00;
        tick(4);
        clear_flags();
        check("back_to_zero", uo4, 8'h00);

        // Glitch of two cycles never reaches DEB.
        ui_in = 8'h11;
        tick(2);
        ui_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("glitch_hold", uo4, 8'h00);
        end

        // XOR written to channel 1.
        ui_in = 8'h02; uio_in = 8'h16;
        tick();
        uio_in = 8'h00;
        tick(2);
        check("opwr_before", uo4, 8'h00);
        tick();
        check("opwr_rise_ch4", uo4, 8'h22);
        check("opwr_rise_ch2", uo2, 8'h22);
        clear_flags();
        check("opwr_steady", uo4, 8'h02);

        // XOR written to channel 3: present on CH=4, ignored on CH=2.
        ui_in = 8'h0A; uio_in = 8'h1E;
        tick();
        uio_in = 8'h00;
        tick(3);
        check("idx3_ch4", uo4, 8'h8A);
        check("idx3_ch2", uo2, 8'h02);
        clear_flags();
        check("idx3_steady", uo4, 8'h0A);

        // Enable freeze mid-count.
        ui_in = 8'h00;
        tick(2);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("freeze_hold", uo4, 8'h0A);
        end
        ena = 1'b1;
        tick();
        check("resume_count", uo4, 8'h0A);
        tick();
        check("resume_commit", uo4, 8'hA0);
        clear_flags();
        check("resume_clear", uo4, 8'h00);

`ifdef GATE_STICKY_EN
        ui_in = 8'h44;
        tick(4);
        check("sticky_rise", uo4, 8'h44);
        tick(3);
        check("sticky_hold", uo4, 8'h44);
        clear_flags();
        check("sticky_clear", uo4, 8'h04);
        ui_in = 8'h00;
        tick(3);
        uio_in = 8'h20;
        tick();
        uio_in = 8'h00;
        check("sticky_set_wins", uo4, 8'h40);
        clear_flags();
        check("sticky_clear2", uo4, 8'h00);
`endif

        // Reset mid-count: op returns to AND, so B-only input keeps Q low.
        ui_in = 8'h01; uio_in = 8'h11;
        tick();
        uio_in = 8'h00;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_ch4", uo4, 8'h00);
        check("midrst_ch2", uo2, 8'h00);
        rst = 1'b0; ui_in = 8'h10;
        tick(5);
        check("midrst_op_and", uo4, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
